coredma_bd_ram_arbiter: RTL and testbench
=========================================

# coredma_bd_ram_arbiter

Two-requester round-robin arbiter that shares the CoreDMA buffer-descriptor RAM between the descriptor fetch engine (requester 0) and the descriptor write-back/status engine (requester 1). It issues one RAM access per cycle, returns read data to the requester that issued it, and supports bounded locked bursts. It sits directly in front of the BD RAM wrapper. Both RAM write and read ports are driven from the single winning request.

## Interface
Parameters:
- WIDTH, 128, RAM data width
- AWIDTH, 7, RAM address width
- RD_LAT, 1, RAM read latency in cycles (REN to valid RAM_RDATA), 1..4
- MAX_BURST, 8, maximum consecutive locked grants to one requester, 2..255

Ports:
- CLOCK  in  1  single clock
- RESET  in  1  synchronous, active-high reset
- REQ_0 / REQ_1  in  1  access request, held until GNT
- WE_0 / WE_1  in  1  1 = write, 0 = read; stable while REQ high
- LOCK_0 / LOCK_1  in  1  request to keep the grant for the next access (burst)
- ADDR_0 / ADDR_1  in  AWIDTH  access address
- WDATA_0 / WDATA_1  in  WIDTH  write data
- GNT_0 / GNT_1  out  1  access accepted this cycle
- RVALID_0 / RVALID_1  out  1  read data valid pulse
- RDATA_0 / RDATA_1  out  WIDTH  read data (both driven from RAM_RDATA)
- RAM_WEN  out  1
- RAM_WADDR  out  AWIDTH
- RAM_WDATA  out  WIDTH
- RAM_REN  out  1
- RAM_RADDR  out  AWIDTH
- RAM_RDATA  in  WIDTH

## Operation
- State: priority pointer PRI (requester with priority), lock owner register OWN (none/0/1), burst counter BCNT (8 bits), read tag pipeline of RD_LAT stages, each holding {valid, id}.
- Grant is combinational from REQ_n, PRI, OWN and BCNT, and is forced to 0 while RESET = 1.
- Grant selection:
  - If OWN = n, REQ_n = 1, and (BCNT < MAX_BURST or the other REQ = 0), grant n.
  - Otherwise, if only one REQ is high, grant it.
  - Otherwise (both high), grant PRI.
- At most one GNT is high per cycle.
- On grant to n:
  - WE_n = 1: RAM_WEN = 1, with RAM_WADDR = ADDR_n and RAM_WDATA = WDATA_n.
  - WE_n = 0: RAM_REN = 1, with RAM_RADDR = ADDR_n, and tag {1, n} enters pipeline stage 0.
- Without a grant: RAM_WEN = RAM_REN = 0, tag stage 0 = {0, x}. Addresses/data are don't-care but are driven from the granted requester or requester 0.
- After each grant to n:
  - PRI <= other requester.
  - If LOCK_n = 1: OWN <= n, and BCNT <= BCNT + 1 if the previous OWN = n, else BCNT <= 1.
  - If LOCK_n = 0: OWN <= none and BCNT <= 0.
- When OWN = n and REQ_n = 0, OWN <= none and BCNT <= 0; PRI is unchanged.
- Forced rotation: when BCNT = MAX_BURST and the other requester is waiting, that requester wins. OWN then follows the winner's LOCK.
- Read return: when the last tag stage is valid with id n, RVALID_n = 1 in that cycle. RDATA_n = RAM_RDATA unconditionally.
- Requesters must not change WE/ADDR/WDATA/LOCK while REQ is high and GNT is low.

## Timing
- Grant-to-RAM latency: 0 cycles (same cycle).
- Read data: RVALID pulses exactly RD_LAT cycles after the GNT cycle. Back-to-back reads give back-to-back RVALIDs in issue order.
- Write followed by a read of the same address on the next grant returns the new data; the RAM provides write-first ordering across cycles.
- Reset values (registered state): PRI = 0, OWN = none, BCNT = 0, all tag stages invalid.
- Reset values (outputs while RESET = 1): GNT_n = 0, RAM_WEN = RAM_REN = 0, RVALID_n = 0.
- Reset mid-operation: in-flight reads are discarded, and no RVALID is asserted for them after RESET deasserts. The first cycle after reset arbitrates from the reset state.
- Both REQ rising in the first cycle after reset: requester 0 wins.

## Test plan
- Reset, then REQ_0 read at addr 5 alone with RD_LAT = 1 -> GNT_0 in the same cycle, RAM_REN = 1, RAM_RADDR = 5, RVALID_0 one cycle later, RVALID_1 = 0.
- Both requesters continuously request writes, no lock -> grants alternate 0,1,0,1…; exactly one RAM_WEN per cycle carrying the correct addr/data.
- REQ_1 holds LOCK_1 for reads with MAX_BURST = 4 while REQ_0 waits -> four consecutive GNT_1, then GNT_0. REQ_0 alone -> GNT_0 every cycle regardless of BCNT.
- RD_LAT = 3 with interleaved reads 0,1,0 -> RVALID_0, RVALID_1, RVALID_0 on cycles +3, +4, +5 with matching RAM data.
- Write 0xA5…A5 to addr 10 via requester 0, then read addr 10 via requester 1 -> RDATA_1 = 0xA5…A5 with RVALID_1.
- Read granted, RESET asserted for 1 cycle before its return -> no RVALID after reset, PRI = 0, and the next simultaneous request grants requester 0.

Source files
------------

// File: rtl/coredma_bd_ram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coredma_bd_ram_arbiter_if                                                  |
// | Requester and BD RAM signal bundle around the BD RAM arbiter.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface coredma_bd_ram_arbiter_if #(
    parameter int WIDTH  = 128,
    parameter int AWIDTH = 7
);
    logic              req_0;
    logic              req_1;
    logic              we_0;
    logic              we_1;
    logic              lock_0;
    logic              lock_1;
    logic [AWIDTH-1:0] addr_0;
    logic [AWIDTH-1:0] addr_1;
    logic [WIDTH-1:0]  wdata_0;
    logic [WIDTH-1:0]  wdata_1;
    logic              gnt_0;
    logic              gnt_1;
    logic              rvalid_0;
    logic              rvalid_1;
    logic [WIDTH-1:0]  rdata_0;
    logic [WIDTH-1:0]  rdata_1;
    logic              ram_wen;
    logic [AWIDTH-1:0] ram_waddr;
    logic [WIDTH-1:0]  ram_wdata;
    logic              ram_ren;
    logic [AWIDTH-1:0] ram_raddr;
    logic [WIDTH-1:0]  ram_rdata;

    // Requesters plus the RAM wrapper: drives requests and read data.
    modport master (
        output req_0, req_1, we_0, we_1, lock_0, lock_1,
        output addr_0, addr_1, wdata_0, wdata_1, ram_rdata,
        input  gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1,
        input  ram_wen, ram_waddr, ram_wdata, ram_ren, ram_raddr
    );

    // The arbiter itself.
    modport slave (
        input  req_0, req_1, we_0, we_1, lock_0, lock_1,
        input  addr_0, addr_1, wdata_0, wdata_1, ram_rdata,
        output gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1,
        output ram_wen, ram_waddr, ram_wdata, ram_ren, ram_raddr
    );
endinterface
`default_nettype wire

// File: rtl/coredma_bd_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coredma_bd_ram_arbiter                                                     |
// | Round-robin arbiter with bounded locked bursts in front of the BD RAM.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module coredma_bd_ram_arbiter #(
    parameter int WIDTH     = 128,
    parameter int AWIDTH    = 7,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  wire logic             CLOCK,
    input  wire logic             RESET,
    coredma_bd_ram_arbiter_if.slave bus
);

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } own_t;

    own_t              own;
    own_t              own_next;
    logic              pri;
    logic              pri_next;
    logic [7:0]        bcnt;
    logic [7:0]        bcnt_next;
    logic [RD_LAT-1:0] tag_valid;
    logic [RD_LAT-1:0] tag_id;

    logic              keep_0;
    logic              keep_1;
    logic              gnt_0;
    logic              gnt_1;
    logic              any_gnt;
    logic              lock_sel;
    logic              rd_issue;
    logic              wr_issue;

    // Grant selection: a lock owner keeps the RAM until its burst budget is
    // spent while the other side waits; otherwise a sole requester wins and
    // a tie goes to the priority pointer.
    always_comb begin
        keep_0 = (own == OWN_0) && bus.req_0 && ((bcnt < BURST_LIMIT) || !bus.req_1);
        keep_1 = (own == OWN_1) && bus.req_1 && ((bcnt < BURST_LIMIT) || !bus.req_0);
        gnt_0  = 1'b0;
        gnt_1  = 1'b0;
        if (!RESET) begin
            if (keep_0) begin
                gnt_0 = 1'b1;
            end else if (keep_1) begin
                gnt_1 = 1'b1;
            end else if (bus.req_0 && bus.req_1) begin
                gnt_0 = ~pri;
                gnt_1 = pri;
            end else begin
                gnt_0 = bus.req_0;
                gnt_1 = bus.req_1;
            end
        end
    end

    assign any_gnt  = gnt_0 | gnt_1;
    assign lock_sel = gnt_1 ? bus.lock_1 : bus.lock_0;
    assign rd_issue = (gnt_0 & ~bus.we_0) | (gnt_1 & ~bus.we_1);
    assign wr_issue = (gnt_0 &  bus.we_0) | (gnt_1 &  bus.we_1);

    // Priority, lock ownership and burst count next-state.
    always_comb begin
        pri_next  = pri;
        own_next  = own;
        bcnt_next = bcnt;
        if (any_gnt) begin
            pri_next = gnt_0;
            if (lock_sel) begin
                own_next = gnt_1 ? OWN_1 : OWN_0;
                if (own_next == own) begin
                    // Saturate so a long solo burst never wraps back below the limit.
                    bcnt_next = (bcnt == 8'hFF) ? bcnt : bcnt + 8'd1;
                end else begin
                    bcnt_next = 8'd1;
                end
            end else begin
                own_next  = OWN_NONE;
                bcnt_next = 8'd0;
            end
        end else if (((own == OWN_0) && !bus.req_0) || ((own == OWN_1) && !bus.req_1)) begin
            own_next  = OWN_NONE;
            bcnt_next = 8'd0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pri       <= 1'b0;
            own       <= OWN_NONE;
            bcnt      <= 8'd0;
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            pri          <= pri_next;
            own          <= own_next;
            bcnt         <= bcnt_next;
            tag_valid[0] <= rd_issue;
            tag_id[0]    <= gnt_1;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    assign bus.gnt_0     = gnt_0;
    assign bus.gnt_1     = gnt_1;
    assign bus.ram_wen   = wr_issue;
    assign bus.ram_ren   = rd_issue;
    assign bus.ram_waddr = gnt_1 ? bus.addr_1  : bus.addr_0;
    assign bus.ram_raddr = gnt_1 ? bus.addr_1  : bus.addr_0;
    assign bus.ram_wdata = gnt_1 ? bus.wdata_1 : bus.wdata_0;

    // Returns are masked during reset so flushed tags never surface.
    assign bus.rvalid_0  = ~RESET & tag_valid[RD_LAT-1] & ~tag_id[RD_LAT-1];
    assign bus.rvalid_1  = ~RESET & tag_valid[RD_LAT-1] &  tag_id[RD_LAT-1];
    assign bus.rdata_0   = bus.ram_rdata;
    assign bus.rdata_1   = bus.ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_coredma_bd_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_coredma_bd_ram_arbiter                                                  |
// | Two arbiters (read latency 1 and 3) on shared stimulus, each with a RAM.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_coredma_bd_ram_arbiter;
    localparam int WIDTH  = 128;
    localparam int AWIDTH = 7;
    localparam int MAXB   = 4;
    localparam int LAT_A  = 1;
    localparam int LAT_B  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              req   [2];
    logic              we    [2];
    logic              lock  [2];
    logic [AWIDTH-1:0] addr  [2];
    logic [WIDTH-1:0]  wdata [2];

    int total = 0;
    int bad   = 0;

    coredma_bd_ram_arbiter_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) bus_a ();
    coredma_bd_ram_arbiter_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) bus_b ();

    coredma_bd_ram_arbiter #(.WIDTH(WIDTH), .AWIDTH(AWIDTH), .RD_LAT(LAT_A), .MAX_BURST(MAXB))
        dut_a (.CLOCK(clk), .RESET(rst), .bus(bus_a.slave));
    coredma_bd_ram_arbiter #(.WIDTH(WIDTH), .AWIDTH(AWIDTH), .RD_LAT(LAT_B), .MAX_BURST(MAXB))
        dut_b (.CLOCK(clk), .RESET(rst), .bus(bus_b.slave));

    assign bus_a.req_0 = req[0];    assign bus_b.req_0 = req[0];
    assign bus_a.req_1 = req[1];    assign bus_b.req_1 = req[1];
    assign bus_a.we_0 = we[0];      assign bus_b.we_0 = we[0];
    assign bus_a.we_1 = we[1];      assign bus_b.we_1 = we[1];
    assign bus_a.lock_0 = lock[0];  assign bus_b.lock_0 = lock[0];
    assign bus_a.lock_1 = lock[1];  assign bus_b.lock_1 = lock[1];
    assign bus_a.addr_0 = addr[0];  assign bus_b.addr_0 = addr[0];
    assign bus_a.addr_1 = addr[1];  assign bus_b.addr_1 = addr[1];
    assign bus_a.wdata_0 = wdata[0]; assign bus_b.wdata_0 = wdata[0];
    assign bus_a.wdata_1 = wdata[1]; assign bus_b.wdata_1 = wdata[1];

    function automatic logic [WIDTH-1:0] pat(input int a);
        return {16{a[7:0] ^ 8'h3C}};
    endfunction

    // RAM models: write-first across cycles, fixed read latency.
    logic [WIDTH-1:0] mem_a  [128];
    logic [WIDTH-1:0] mem_b  [128];
    logic [WIDTH-1:0] pipe_a [LAT_A];
    logic [WIDTH-1:0] pipe_b [LAT_B];
    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_a[i] = pat(i);
            mem_b[i] = pat(i);
        end
    end
    always @(posedge clk) begin
        if (bus_a.ram_wen) mem_a[bus_a.ram_waddr] <= bus_a.ram_wdata;
        if (bus_b.ram_wen) mem_b[bus_b.ram_waddr] <= bus_b.ram_wdata;
        pipe_a[0] <= mem_a[bus_a.ram_raddr];
        pipe_b[0] <= mem_b[bus_b.ram_raddr];
        for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
        for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign bus_a.ram_rdata = pipe_a[LAT_A-1];
    assign bus_b.ram_rdata = pipe_b[LAT_B-1];

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int n, input logic r, input logic w, input logic l,
                           input logic [AWIDTH-1:0] a, input logic [WIDTH-1:0] d);
        req[n] = r; we[n] = w; lock[n] = l; addr[n] = a; wdata[n] = d;
    endtask

    task automatic idle();
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_req(0, 1'b1, 1'b1, 1'b0, 7'd1, '0);
        set_req(1, 1'b1, 1'b0, 1'b0, 7'd2, '0);
        #1;
        chk("rst_gnt0", bus_a.gnt_0, 0);
        chk("rst_gnt1", bus_a.gnt_1, 0);
        chk("rst_wen", bus_a.ram_wen, 0);
        chk("rst_ren", bus_a.ram_ren, 0);
        chk("rst_rvalid0", bus_a.rvalid_0, 0);
        chk("rst_rvalid1", bus_b.rvalid_1, 0);
        @(negedge clk);
        rst = 1'b0;
        idle();
    endtask

    typedef struct {
        logic r0, r1, l0, l1, w0, w1, g0, g1;
    } row_t;
    row_t tbl [18];

    function automatic row_t mk(input logic r0, r1, l0, l1, w0, w1, g0, g1);
        row_t r;
        r.r0 = r0; r.r1 = r1; r.l0 = l0; r.l1 = l1; r.w0 = w0; r.w1 = w1; r.g0 = g0; r.g1 = g1;
        return r;
    endfunction

    typedef struct {
        int               due;
        int               id;
        logic [WIDTH-1:0] data;
    } rd_t;
    rd_t rq [2][$];

    initial begin
        int               lat [2];
        logic [WIDTH-1:0] mmem [128];
        int               m_pri, m_own, m_cnt, cyc, eg;
        bit               held [2];
        logic             ew, er;

        // Lock burst with MAX_BURST=4, solo lock past the limit, then alternation.
        tbl[0] = mk(0, 1, 0, 1, 0, 0, 0, 1);
        for (int i = 1; i <= 3; i++) tbl[i] = mk(1, 1, 0, 1, 1, 0, 0, 1);
        tbl[4] = mk(1, 1, 0, 1, 1, 0, 1, 0);
        for (int i = 5; i <= 10; i++) tbl[i] = mk(1, 0, 1, 0, 1, 0, 1, 0);
        tbl[11] = mk(1, 1, 1, 0, 1, 1, 0, 1);
        tbl[12] = mk(1, 1, 1, 0, 1, 1, 1, 0);
        tbl[13] = mk(1, 1, 0, 0, 1, 1, 1, 0);
        tbl[14] = mk(1, 1, 0, 0, 1, 1, 0, 1);
        tbl[15] = mk(1, 1, 0, 0, 1, 1, 1, 0);
        tbl[16] = mk(1, 1, 0, 0, 1, 1, 0, 1);
        tbl[17] = mk(0, 0, 0, 0, 1, 1, 0, 0);

        idle();
        do_reset();

        // Single read at address 5, latency 1.
        set_req(0, 1'b1, 1'b0, 1'b0, 7'd5, '0);
        #1;
        chk("rd5_gnt0", bus_a.gnt_0, 1);
        chk("rd5_gnt1", bus_a.gnt_1, 0);
        chk("rd5_ren", bus_a.ram_ren, 1);
        chk("rd5_wen", bus_a.ram_wen, 0);
        chk("rd5_raddr", bus_a.ram_raddr, 5);
        @(negedge clk); idle(); #1;
        chk("rd5_rvalid0", bus_a.rvalid_0, 1);
        chk("rd5_rvalid1", bus_a.rvalid_1, 0);
        chk("rd5_rdata0", bus_a.rdata_0, pat(5));

        // Write then read back through the other requester.
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 1'b0, 7'd10, {16{8'hA5}});
        #1;
        chk("wr10_gnt0", bus_a.gnt_0, 1);
        chk("wr10_wen", bus_a.ram_wen, 1);
        chk("wr10_waddr", bus_a.ram_waddr, 10);
        chk("wr10_wdata", bus_a.ram_wdata, {16{8'hA5}});
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b1, 1'b0, 1'b0, 7'd10, '0);
        #1;
        chk("rd10_gnt1", bus_a.gnt_1, 1);
        chk("rd10_raddr", bus_a.ram_raddr, 10);
        @(negedge clk); idle(); #1;
        chk("rd10_rvalid1_a", bus_a.rvalid_1, 1);
        chk("rd10_rdata1_a", bus_a.rdata_1, {16{8'hA5}});
        @(negedge clk); #1;
        chk("rd10_early_b", bus_b.rvalid_1, 0);
        @(negedge clk); #1;
        chk("rd10_rvalid1_b", bus_b.rvalid_1, 1);
        chk("rd10_rdata1_b", bus_b.rdata_1, {16{8'hA5}});

        // Interleaved reads 0,1,0 on the latency-3 instance.
        @(negedge clk); set_req(0, 1'b1, 1'b0, 1'b0, 7'd20, '0); #1;
        chk("il_g0", bus_b.gnt_0, 1);
        @(negedge clk); idle(); set_req(1, 1'b1, 1'b0, 1'b0, 7'd21, '0); #1;
        chk("il_g1", bus_b.gnt_1, 1);
        @(negedge clk); idle(); set_req(0, 1'b1, 1'b0, 1'b0, 7'd22, '0); #1;
        chk("il_g2", bus_b.gnt_0, 1);
        @(negedge clk); idle(); #1;
        chk("il_rv0_a", bus_b.rvalid_0, 1);
        chk("il_rv0_b", bus_b.rvalid_1, 0);
        chk("il_rd0", bus_b.rdata_0, pat(20));
        @(negedge clk); #1;
        chk("il_rv1_a", bus_b.rvalid_1, 1);
        chk("il_rv1_b", bus_b.rvalid_0, 0);
        chk("il_rd1", bus_b.rdata_1, pat(21));
        @(negedge clk); #1;
        chk("il_rv2_a", bus_b.rvalid_0, 1);
        chk("il_rv2_b", bus_b.rvalid_1, 0);
        chk("il_rd2", bus_b.rdata_0, pat(22));

        // Reset while a read is in flight; leave priority at 1 beforehand.
        @(negedge clk); set_req(0, 1'b1, 1'b0, 1'b0, 7'd30, '0); #1;
        chk("flush_gnt", bus_b.gnt_0, 1);
        @(negedge clk); idle(); rst = 1'b1; #1;
        chk("flush_rst_rv", bus_b.rvalid_0, 0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("flush_rv0_b", bus_b.rvalid_0, 0);
            chk("flush_rv0_a", bus_a.rvalid_0, 0);
            @(negedge clk);
        end
        set_req(0, 1'b1, 1'b1, 1'b0, 7'd40, '0);
        set_req(1, 1'b1, 1'b1, 1'b0, 7'd41, '0);
        #1;
        chk("flush_both_g0", bus_a.gnt_0, 1);
        chk("flush_both_g1", bus_a.gnt_1, 0);

        // Table-driven grant sequence from reset.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            set_req(0, tbl[i].r0, tbl[i].w0, tbl[i].l0, 7'd3, pat(100));
            set_req(1, tbl[i].r1, tbl[i].w1, tbl[i].l1, 7'd9, pat(101));
            #1;
            ew = (tbl[i].g0 & tbl[i].w0) | (tbl[i].g1 & tbl[i].w1);
            er = (tbl[i].g0 & ~tbl[i].w0) | (tbl[i].g1 & ~tbl[i].w1);
            chk($sformatf("tbl%0d_gnt0", i), bus_a.gnt_0, tbl[i].g0);
            chk($sformatf("tbl%0d_gnt1", i), bus_a.gnt_1, tbl[i].g1);
            chk($sformatf("tbl%0d_gnt1_b", i), bus_b.gnt_1, tbl[i].g1);
            chk($sformatf("tbl%0d_wen", i), bus_a.ram_wen, ew);
            chk($sformatf("tbl%0d_ren", i), bus_a.ram_ren, er);
            if (ew) chk($sformatf("tbl%0d_waddr", i), bus_a.ram_waddr, tbl[i].g1 ? 9 : 3);
            if (ew) chk($sformatf("tbl%0d_wdata", i), bus_a.ram_wdata, tbl[i].g1 ? pat(101) : pat(100));
            if (er) chk($sformatf("tbl%0d_raddr", i), bus_a.ram_raddr, tbl[i].g1 ? 9 : 3);
            @(negedge clk);
        end

        // Random traffic against a rule-level model, addresses 64..79 only.
        do_reset();
        lat[0] = LAT_A; lat[1] = LAT_B;
        for (int i = 0; i < 128; i++) mmem[i] = pat(i);
        m_pri = 0; m_own = -1; m_cnt = 0; cyc = 0;
        held[0] = 0; held[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) @(negedge clk);
            cyc++;
            for (int n = 0; n < 2; n++) begin
                if (!held[n]) begin
                    req[n]   = ($urandom % 4) != 0;
                    we[n]    = $urandom % 2;
                    lock[n]  = ($urandom % 3) != 0;
                    addr[n]  = AWIDTH'(64 + $urandom_range(0, 15));
                    wdata[n] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            #1;
            eg = -1;
            if (m_own >= 0 && req[m_own] && (m_cnt < MAXB || !req[1-m_own])) eg = m_own;
            else if (req[0] && req[1]) eg = m_pri;
            else if (req[0]) eg = 0;
            else if (req[1]) eg = 1;

            chk("rnd_gnt0", bus_a.gnt_0, eg == 0);
            chk("rnd_gnt1", bus_a.gnt_1, eg == 1);
            chk("rnd_gnt0_b", bus_b.gnt_0, eg == 0);
            chk("rnd_gnt1_b", bus_b.gnt_1, eg == 1);
            chk("rnd_wen", bus_a.ram_wen, eg >= 0 && we[eg]);
            chk("rnd_ren", bus_a.ram_ren, eg >= 0 && !we[eg]);
            if (eg >= 0 && we[eg]) begin
                chk("rnd_waddr", bus_a.ram_waddr, addr[eg]);
                chk("rnd_wdata", bus_a.ram_wdata, wdata[eg]);
            end
            if (eg >= 0 && !we[eg]) chk("rnd_raddr", bus_a.ram_raddr, addr[eg]);

            for (int k = 0; k < 2; k++) begin
                logic             rv0, rv1, due0, due1;
                logic [WIDTH-1:0] rd0, rd1;
                rv0 = k ? bus_b.rvalid_0 : bus_a.rvalid_0;
                rv1 = k ? bus_b.rvalid_1 : bus_a.rvalid_1;
                rd0 = k ? bus_b.rdata_0  : bus_a.rdata_0;
                rd1 = k ? bus_b.rdata_1  : bus_a.rdata_1;
                due0 = rq[k].size() > 0 && rq[k][0].due == cyc && rq[k][0].id == 0;
                due1 = rq[k].size() > 0 && rq[k][0].due == cyc && rq[k][0].id == 1;
                chk($sformatf("rnd_rvalid0_lat%0d", lat[k]), rv0, due0);
                chk($sformatf("rnd_rvalid1_lat%0d", lat[k]), rv1, due1);
                if (due0) chk($sformatf("rnd_rdata0_lat%0d", lat[k]), rd0, rq[k][0].data);
                if (due1) chk($sformatf("rnd_rdata1_lat%0d", lat[k]), rd1, rq[k][0].data);
                if (due0 || due1) void'(rq[k].pop_front());
            end

            if (eg >= 0) begin
                if (we[eg]) begin
                    mmem[addr[eg]] = wdata[eg];
                end else begin
                    for (int k = 0; k < 2; k++)
                        rq[k].push_back('{due: cyc + lat[k], id: eg, data: mmem[addr[eg]]});
                end
                m_pri = 1 - eg;
                if (lock[eg]) begin
                    m_cnt = (m_own == eg) ? m_cnt + 1 : 1;
                    m_own = eg;
                end else begin
                    m_own = -1;
                    m_cnt = 0;
                end
            end else if (m_own >= 0 && !req[m_own]) begin
                m_own = -1;
                m_cnt = 0;
            end
            held[0] = req[0] && eg != 0;
            held[1] = req[1] && eg != 1;
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
